ysyx_24110015_alu_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared combinational ALU in the NPC execute path. It accepts operations from two clients (requester 0 = EXU integer ops, requester 1 = branch/compare unit) over valid/ready handshakes and issues at most one operation per cycle to the ALU. Each result is returned through a per-requester one-entry response buffer, tagged with the requester's transaction tag.

---
 rtl/ysyx_24110015_alu_arb.sv | 191 +++++++++++++++++++
 tb/tb_ysyx_24110015_alu_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_alu_arb.sv
// ysyx_24110015_alu_arb
// Two-requester arbiter and sequencer in front of the shared combinational ALU.
// Accepted requests pass through a one-entry issue register that drives the ALU.
// Each result lands in the owner's one-entry response buffer with its tag echoed.
// Build option: define ALU_ARB_RR_EN for round-robin tie breaking.
// Without it, requester 0 has fixed priority on a tie.
module ysyx_24110015_alu_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [TAG_WIDTH-1:0]  req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [TAG_WIDTH-1:0]  req1_tag,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic [TAG_WIDTH-1:0]  rsp0_tag,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic [TAG_WIDTH-1:0]  rsp1_tag,
    output logic [3:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_data1,
    output logic [DATA_WIDTH-1:0] alu_data2,
    input  logic [DATA_WIDTH-1:0] alu_out
);

    // Issue register
    logic                  r_iss_v;
    logic [3:0]            r_iss_op;
    logic [DATA_WIDTH-1:0] r_iss_a;
    logic [DATA_WIDTH-1:0] r_iss_b;
    logic [TAG_WIDTH-1:0]  r_iss_tag;
    logic                  r_iss_owner;

    // Response buffers
    logic                  r_rsp0_v;
    logic [DATA_WIDTH-1:0] r_rsp0_data;
    logic [TAG_WIDTH-1:0]  r_rsp0_tag;
    logic                  r_rsp1_v;
    logic [DATA_WIDTH-1:0] r_rsp1_data;
    logic [TAG_WIDTH-1:0]  r_rsp1_tag;

    // Handshake and flow-control wires
    logic                  w_owner_free;
    logic                  w_iss_move;
    logic                  w_iss_free;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_acc0;
    logic                  w_acc1;
    logic [3:0]            w_sel_op;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;
    logic [TAG_WIDTH-1:0]  w_sel_tag;

    // The issue register may advance when its owner's buffer is empty or being drained now
    always_comb begin
        w_owner_free = 1'b0;
        if (r_iss_owner) begin
            w_owner_free = !r_rsp1_v || rsp1_ready;
        end else begin
            w_owner_free = !r_rsp0_v || rsp0_ready;
        end
        w_iss_move = r_iss_v && w_owner_free;
        w_iss_free = !r_iss_v || w_iss_move;
    end

`ifdef ALU_ARB_RR_EN
    logic r_last;

    // Round-robin grant: on a tie the requester that was not accepted last wins
    always_comb begin
        w_grant0 = req0_valid && (!req1_valid || r_last);
        w_grant1 = req1_valid && (!req0_valid || !r_last);
    end

    // Remember which requester completed the most recent handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_acc0) begin
            r_last <= 1'b0;
        end else if (w_acc1) begin
            r_last <= 1'b1;
        end
    end
`else
    // Fixed-priority grant: requester 0 always wins a tie
    always_comb begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid && !req0_valid;
    end
`endif

    // Ready only when granted, the issue slot frees up this cycle, and not in reset
    always_comb begin
        req0_ready = w_grant0 && w_iss_free && rst_n;
        req1_ready = w_grant1 && w_iss_free && rst_n;
        w_acc0     = req0_valid && req0_ready;
        w_acc1     = req1_valid && req1_ready;
    end

    // Select the payload of whichever requester is being accepted
    always_comb begin
        if (w_acc1) begin
            w_sel_op  = req1_op;
            w_sel_a   = req1_a;
            w_sel_b   = req1_b;
            w_sel_tag = req1_tag;
        end else begin
            w_sel_op  = req0_op;
            w_sel_a   = req0_a;
            w_sel_b   = req0_b;
            w_sel_tag = req0_tag;
        end
    end

    // Load the issue register on a handshake, empty it when its result moves out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iss_v     <= 1'b0;
            r_iss_op    <= '0;
            r_iss_a     <= '0;
            r_iss_b     <= '0;
            r_iss_tag   <= '0;
            r_iss_owner <= 1'b0;
        end else if (w_acc0 || w_acc1) begin
            r_iss_v     <= 1'b1;
            r_iss_op    <= w_sel_op;
            r_iss_a     <= w_sel_a;
            r_iss_b     <= w_sel_b;
            r_iss_tag   <= w_sel_tag;
            r_iss_owner <= w_acc1;
        end else if (w_iss_move) begin
            r_iss_v     <= 1'b0;
        end
    end

    // Requester 0 response buffer: capture the ALU result, or drain on consume
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp0_v    <= 1'b0;
            r_rsp0_data <= '0;
            r_rsp0_tag  <= '0;
        end else if (w_iss_move && !r_iss_owner) begin
            r_rsp0_v    <= 1'b1;
            r_rsp0_data <= alu_out;
            r_rsp0_tag  <= r_iss_tag;
        end else if (rsp0_ready) begin
            r_rsp0_v    <= 1'b0;
        end
    end

    // Requester 1 response buffer: capture the ALU result, or drain on consume
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp1_v    <= 1'b0;
            r_rsp1_data <= '0;
            r_rsp1_tag  <= '0;
        end else if (w_iss_move && r_iss_owner) begin
            r_rsp1_v    <= 1'b1;
            r_rsp1_data <= alu_out;
            r_rsp1_tag  <= r_iss_tag;
        end else if (rsp1_ready) begin
            r_rsp1_v    <= 1'b0;
        end
    end

    assign alu_op     = r_iss_op;
    assign alu_data1  = r_iss_a;
    assign alu_data2  = r_iss_b;
    assign rsp0_valid = r_rsp0_v;
    assign rsp0_data  = r_rsp0_data;
    assign rsp0_tag   = r_rsp0_tag;
    assign rsp1_valid = r_rsp1_v;
    assign rsp1_data  = r_rsp1_data;
    assign rsp1_tag   = r_rsp1_tag;

endmodule

// File: tb/tb_ysyx_24110015_alu_arb.sv
// Testbench for ysyx_24110015_alu_arb.
// A transaction-level model (queues for the issue slot and response buffers) predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_ysyx_24110015_alu_arb;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [3:0]  rsp0_tag, rsp1_tag;
    logic [3:0]  alu_op;
    logic [31:0] alu_data1, alu_data2, alu_out;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic        owner;
    } iss_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
    } rsp_t;

    iss_t issQ[$];
    rsp_t rspQ0[$];
    rsp_t rspQ1[$];
    int   mLast;
    bit   expReady0, expReady1;
    bit   pend0, pend1;
    int   nChecks;
    int   nFails;

    ysyx_24110015_alu_arb #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_tag   (rsp0_tag),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_tag   (rsp1_tag),
        .alu_op     (alu_op),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU semantics, also used as the ALU attached to the DUT
    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            default:  return 32'd0;
        endcase
    endfunction

    always_comb alu_out = aluRef(alu_op, alu_data1, alu_data2);

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic rn,
        input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] t0,
        input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] t1,
        input logic r0, input logic r1);
        rst_n      = rn;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0; req0_tag = t0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1; req1_tag = t1;
        rsp0_ready = r0;
        rsp1_ready = r1;
    endtask

    task automatic applyIdle(input logic rn, input logic r0, input logic r1);
        applyStimulus(rn, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, r0, r1);
    endtask

    // Predict handshake readiness from the arbitration rules and compare every output
    task automatic checkOutput();
        int  winner;
        bit  issFree;
        winner = -1;
        if (req0_valid && req1_valid) winner = RR ? ((mLast == 0) ? 1 : 0) : 0;
        else if (req0_valid) winner = 0;
        else if (req1_valid) winner = 1;
        issFree = 1'b1;
        if (issQ.size() > 0) begin
            if (issQ[0].owner) issFree = (rspQ1.size() == 0) || rsp1_ready;
            else               issFree = (rspQ0.size() == 0) || rsp0_ready;
        end
        expReady0 = rst_n && issFree && (winner == 0);
        expReady1 = rst_n && issFree && (winner == 1);
        checkVal("req0_ready", req0_ready, expReady0);
        checkVal("req1_ready", req1_ready, expReady1);
        checkVal("rsp0_valid", rsp0_valid, rspQ0.size() > 0);
        checkVal("rsp1_valid", rsp1_valid, rspQ1.size() > 0);
        if (rspQ0.size() > 0) begin
            checkVal("rsp0_data", rsp0_data, rspQ0[0].data);
            checkVal("rsp0_tag", rsp0_tag, rspQ0[0].tag);
        end
        if (rspQ1.size() > 0) begin
            checkVal("rsp1_data", rsp1_data, rspQ1[0].data);
            checkVal("rsp1_tag", rsp1_tag, rspQ1[0].tag);
        end
        if (issQ.size() > 0) begin
            checkVal("alu_op", alu_op, issQ[0].op);
            checkVal("alu_data1", alu_data1, issQ[0].a);
            checkVal("alu_data2", alu_data2, issQ[0].b);
        end
    endtask

    // Advance the transaction model across one clock edge
    task automatic stepModel();
        bit   acc0, acc1, move;
        iss_t it;
        rsp_t rs;
        acc0 = req0_valid && expReady0;
        acc1 = req1_valid && expReady1;
        pend0 = req0_valid && !acc0;
        pend1 = req1_valid && !acc1;
        if (!rst_n) begin
            issQ.delete();
            rspQ0.delete();
            rspQ1.delete();
            mLast = 1;
            return;
        end
        move = 1'b0;
        if (issQ.size() > 0) begin
            if (issQ[0].owner) move = (rspQ1.size() == 0) || rsp1_ready;
            else               move = (rspQ0.size() == 0) || rsp0_ready;
        end
        if (rspQ0.size() > 0 && rsp0_ready) void'(rspQ0.pop_front());
        if (rspQ1.size() > 0 && rsp1_ready) void'(rspQ1.pop_front());
        if (move) begin
            it = issQ.pop_front();
            rs.data = aluRef(it.op, it.a, it.b);
            rs.tag  = it.tag;
            if (it.owner) rspQ1.push_back(rs);
            else          rspQ0.push_back(rs);
        end
        if (acc0) begin
            it.op = req0_op; it.a = req0_a; it.b = req0_b; it.tag = req0_tag; it.owner = 1'b0;
            issQ.push_back(it);
            mLast = 0;
        end
        if (acc1) begin
            it.op = req1_op; it.a = req1_a; it.b = req1_b; it.tag = req1_tag; it.owner = 1'b1;
            issQ.push_back(it);
            mLast = 1;
        end
    endtask

    task automatic cycle();
        #2;
        checkOutput();
        stepModel();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] xa, xb;

    initial begin
        nChecks = 0;
        nFails  = 0;
        mLast   = 1;
        pend0   = 1'b0;
        pend1   = 1'b0;

        // Power-up reset, outputs not yet meaningful
        applyStimulus(1'b0, 1'b1, ALU_ADD, 32'd1, 32'd1, 4'd1, 1'b1, ALU_ADD, 32'd2, 32'd2, 4'd2, 1'b1, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        #1;
        checkVal("lit reset req0_ready", req0_ready, 1'b0);
        checkVal("lit reset rsp0_valid", rsp0_valid, 1'b0);
        checkVal("lit reset rsp1_valid", rsp1_valid, 1'b0);
        checkVal("lit reset alu_op", alu_op, 4'd0);
        checkVal("lit reset rsp0_data", rsp0_data, 32'd0);
        checkVal("lit reset rsp1_tag", rsp1_tag, 4'd0);
        cycle();

        // Single SUB op: 7 - 3 = 4, tag 5
        applyStimulus(1'b1, 1'b1, ALU_SUB, 32'd7, 32'd3, 4'd5, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
        #1; checkVal("lit single accept", req0_ready, 1'b1);
        cycle();
        applyIdle(1'b1, 1'b1, 1'b1);
        #1; checkVal("lit single alu_op", alu_op, ALU_SUB);
        checkVal("lit single alu_data1", alu_data1, 32'd7);
        checkVal("lit single early rsp", rsp0_valid, 1'b0);
        cycle();
        #1; checkVal("lit single rsp_valid", rsp0_valid, 1'b1);
        checkVal("lit single rsp_data", rsp0_data, 32'd4);
        checkVal("lit single rsp_tag", rsp0_tag, 4'd5);
        cycle();
        #1; checkVal("lit single one-cycle", rsp0_valid, 1'b0);
        cycle();

        // Reset so the first tie goes to requester 0, then sustained contention
        applyIdle(1'b0, 1'b1, 1'b1);
        cycle();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, ALU_ADD, 32'(i), 32'd100, 4'(2 * i),
                          1'b1, ALU_OR, 32'(i), 32'd200, 4'(2 * i + 1), 1'b1, 1'b1);
            #1;
            checkVal("lit contention req0_ready", req0_ready, RR ? (i % 2 == 0) : 1'b1);
            checkVal("lit contention req1_ready", req1_ready, RR ? (i % 2 == 1) : 1'b0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            applyIdle(1'b1, 1'b1, 1'b1);
            cycle();
        end

        // Backpressure on requester 0 with head-of-line blocking of requester 1
        applyStimulus(1'b1, 1'b1, ALU_ADD, 32'd10, 32'd20, 4'd1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        #1; checkVal("lit bp accept1", req0_ready, 1'b1);
        cycle();
        applyStimulus(1'b1, 1'b1, ALU_ADD, 32'd30, 32'd40, 4'd2, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        #1; checkVal("lit bp accept2", req0_ready, 1'b1);
        cycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, ALU_ADD, 32'd50, 32'd60, 4'd3, 1'b1, ALU_AND, 32'd5, 32'd6, 4'd7, 1'b0, 1'b1);
            #1; checkVal("lit bp req0 blocked", req0_ready, 1'b0);
            checkVal("lit bp req1 hol", req1_ready, 1'b0);
            checkVal("lit bp rsp0_data", rsp0_data, 32'd30);
            checkVal("lit bp alu_data1", alu_data1, 32'd30);
            cycle();
        end
        applyStimulus(1'b1, 1'b1, ALU_ADD, 32'd50, 32'd60, 4'd3, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
        #1; checkVal("lit bp resume", req0_ready, 1'b1);
        cycle();
        applyIdle(1'b1, 1'b1, 1'b1);
        #1; checkVal("lit bp drain2", rsp0_data, 32'd70);
        cycle();
        #1; checkVal("lit bp drain3", rsp0_data, 32'd110);
        checkVal("lit bp drain3 tag", rsp0_tag, 4'd3);
        cycle();
        cycle();

        // Back-to-back XOR ops
        for (int i = 0; i < 7; i++) begin
            xa = 32'h1234_0000 + 32'(i * 3);
            xb = 32'h00FF_00F0 ^ 32'(i);
            if (i < 4) applyStimulus(1'b1, 1'b1, ALU_XOR, xa, xb, 4'(8 + i), 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
            else       applyIdle(1'b1, 1'b1, 1'b1);
            #1;
            if (i < 4) checkVal("lit b2b accept", req0_ready, 1'b1);
            checkVal("lit b2b rsp_valid", rsp0_valid, (i >= 2) && (i < 6));
            if (i >= 2 && i < 6) begin
                checkVal("lit b2b rsp_data", rsp0_data,
                         (32'h1234_0000 + 32'((i - 2) * 3)) ^ (32'h00FF_00F0 ^ 32'(i - 2)));
            end
            cycle();
        end

        // Unused opcode returns zero with the tag echoed
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 1'b1, 1'b1);
        cycle();
        applyIdle(1'b1, 1'b1, 1'b1);
        #1; checkVal("lit unused alu_op", alu_op, 4'b1110);
        cycle();
        #1; checkVal("lit unused rsp_valid", rsp1_valid, 1'b1);
        checkVal("lit unused rsp_data", rsp1_data, 32'd0);
        checkVal("lit unused rsp_tag", rsp1_tag, 4'd9);
        cycle();

        // Reset while issue register and rsp1 buffer are both full
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, ALU_ADD, 32'd1, 32'd2, 4'd3, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, ALU_ADD, 32'd4, 32'd5, 4'd4, 1'b1, 1'b0);
        cycle();
        applyIdle(1'b1, 1'b1, 1'b0);
        #1; checkVal("lit rst full rsp1", rsp1_valid, 1'b1);
        checkVal("lit rst full alu_data1", alu_data1, 32'd4);
        cycle();
        applyIdle(1'b0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b1, ALU_ADD, 32'd8, 32'd8, 4'd6, 1'b1, ALU_ADD, 32'd9, 32'd9, 4'd7, 1'b1, 1'b1);
        #1; checkVal("lit post-rst rsp0_valid", rsp0_valid, 1'b0);
        checkVal("lit post-rst rsp1_valid", rsp1_valid, 1'b0);
        checkVal("lit post-rst alu_op", alu_op, 4'd0);
        checkVal("lit post-rst alu_data1", alu_data1, 32'd0);
        checkVal("lit post-rst alu_data2", alu_data2, 32'd0);
        checkVal("lit post-rst tie req0", req0_ready, 1'b1);
        checkVal("lit post-rst tie req1", req1_ready, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            applyIdle(1'b1, 1'b1, 1'b1);
            cycle();
        end

        // Randomized traffic with random backpressure and occasional reset
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if (!pend0) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_op    = 4'($urandom_range(0, 15));
                req0_a     = $urandom;
                req0_b     = $urandom;
                req0_tag   = 4'($urandom_range(0, 15));
            end
            if (!pend1) begin
                req1_valid = ($urandom_range(0, 99) < 60);
                req1_op    = 4'($urandom_range(0, 15));
                req1_a     = $urandom;
                req1_b     = $urandom;
                req1_tag   = 4'($urandom_range(0, 15));
            end
            rsp0_ready = ($urandom_range(0, 99) < 70);
            rsp1_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
